bank_arb: RTL and testbench
===========================

Name: bank_arb

Overview:
- Parametrised successor to the fixed 3-reader/3-writer data bank.
- Owns one inferred 2^A x W simple-dual-port RAM and arbitrates NRD read requesters onto its read port and NWR write requesters onto its write port.
- Arbitration is either fixed priority or round-robin.
- Adds what the old bank lacked: per-requester read-data valid tagging aligned to the RAM's 1-cycle read latency, and optional write-to-read bypass on same-address collision.

Parameters:
- W, 128, data word width in bits.
- A, 9, address width; depth = 2^A words.
- NRD, 3, number of read requesters (>=1).
- NWR, 3, number of write requesters (>=1).
- RR, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
- BYPASS, 1, 1 = same-cycle same-address read returns the write data; 0 = returns the old RAM contents.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  NRD  per-requester read request (replaces csel&en).
- rd_addr  in  NRD*A  packed read addresses; requester i at [i*A +: A].
- rd_grnt  out  NRD  combinational one-hot-or-zero read grant.
- rd_word  out  W  shared read data, registered.
- rd_vld  out  NRD  rd_vld[i]=1 means rd_word is requester i's data.
- wr_req  in  NWR  per-requester write request.
- wr_addr  in  NWR*A  packed write addresses.
- wr_word  in  NWR*W  packed write data; requester j at [j*W +: W].
- wr_grnt  out  NWR  combinational one-hot-or-zero write grant; a write occurs on the clock edge of the grant cycle.

Behaviour:
- Grants:
  - Combinational in the same cycle as the request; at most one bit set per grant vector.
  - A grant is issued whenever any request is high and rst=0.
  - All grants are 0 while rst=1.
- Fixed mode (RR=0): lowest asserted index wins.
- Round-robin mode (RR=1):
  - Each port keeps a pointer register, rd_last (log2 NRD bits) or wr_last.
  - The search starts at last+1 modulo N and wraps around; the first asserted request wins.
  - The pointer loads the granted index on every granted cycle and holds when there is no grant.
  - Reset value is N-1, so index 0 has first priority after reset.
  - With N=1 the pointer is constant 0.
- Read pipeline:
  - Granted address feeds the RAM.
  - Next cycle: rd_word = RAM[addr], and rd_vld = previous cycle's rd_grnt (registered).
  - Latency is exactly 1 cycle, and back-to-back reads are allowed every cycle.
  - rd_word holds its last value when no read is granted, with rd_vld=0.
- Write: on the granted cycle's edge, RAM[wr_addr sel] <= wr_word sel. No write happens when there is no grant.
- Collision (read grant and write grant, same address, same cycle):
  - BYPASS=1: the next-cycle rd_word equals the written word.
  - BYPASS=0: rd_word equals the pre-write contents.
  - Different addresses do not interact.
- Reset values:
  - rd_word=0, rd_vld=0, pointers=N-1.
  - RAM contents are not reset.
- Reset mid-operation:
  - Asserting rst clears rd_vld immediately (async), dropping any read in flight.
  - A write presented in a cycle where rst is asserted does not occur.
  - After deassertion, the first granted read returns valid data 1 cycle later.
- Request holding: a requester holds req/addr/data until it sees its grant; an ungranted request has no effect. A requester may change its address every cycle.
- Illegal or edge cases: none. An address wraps naturally at 2^A-1 (A-bit field).

Test Plan:
- Reset then single write/read: wr_req=001, addr 0x005, data 0xA5..A5; next cycle rd_req=001, addr 0x005 -> wr_grnt=001; 1 cycle later rd_vld=001, rd_word=0xA5..A5.
- Fixed priority contention (RR=0): rd_req=111 held 3 cycles -> rd_grnt=001 every cycle; rd_vld=001 lags by 1 cycle.
- Round-robin (RR=1):
  - rd_req=111 held 4 cycles -> rd_grnt sequence 001,010,100,001.
  - Then rd_req=100 only -> 100, and the pointer is left at 2.
- Collision: write 0x1111 then write 0x2222 to addr 0x1FF concurrently with a read of 0x1FF -> BYPASS=1 returns 0x2222; BYPASS=0 returns 0x1111.
- Back-to-back streaming: reads of addrs 0..7 on consecutive cycles after preloading data=addr*3 -> rd_word 0,3,6,...,21 with rd_vld continuously high, no bubbles.
- Reset mid-read: rd grant in cycle N, rst pulsed asynchronously before edge N+1 -> rd_vld=0, rd_word=0, and the round-robin pointer returns to N-1.

Source files
------------

// File: rtl/bank_arb.sv
// bank_arb: arbitrated 2^A x W simple-dual-port RAM with per-requester read-valid tags
// and optional same-address write-to-read bypass.
module bank_arb_pick #(
  parameter int N  = 3,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grnt
);
  localparam int L = N > 1 ? $clog2(N) : 1;
  logic [L-1:0] last, base, p, idx;
  // Fixed priority is round-robin searching from a pinned base of N-1, i.e. starting at index 0
  always_comb begin
    base = RR != 0 ? last : L'(N - 1);
    grnt = '0;
    idx = last;
    p = '0;
    for (int k = 1; k <= N; k++) begin
      p = L'((int'(base) + k) % N);
      if (!rst && grnt == '0 && req[p]) begin
        grnt[p] = 1'b1;
        idx = p;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= L'(N - 1);
    else if (|grnt) last <= idx;
endmodule

module bank_arb #(
  parameter int W      = 128,
  parameter int A      = 9,
  parameter int NRD    = 3,
  parameter int NWR    = 3,
  parameter int RR     = 0,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NRD-1:0]   rd_req,
  input  logic [NRD*A-1:0] rd_addr,
  output logic [NRD-1:0]   rd_grnt,
  output logic [W-1:0]     rd_word,
  output logic [NRD-1:0]   rd_vld,
  input  logic [NWR-1:0]   wr_req,
  input  logic [NWR*A-1:0] wr_addr,
  input  logic [NWR*W-1:0] wr_word,
  output logic [NWR-1:0]   wr_grnt
);
  logic [W-1:0] mem [2**A];
  logic [A-1:0] ra, wa;
  logic [W-1:0] wd;
  bank_arb_pick #(.N(NRD), .RR(RR)) u_rd (.clk(clk), .rst(rst), .req(rd_req), .grnt(rd_grnt));
  bank_arb_pick #(.N(NWR), .RR(RR)) u_wr (.clk(clk), .rst(rst), .req(wr_req), .grnt(wr_grnt));
  // Grants are one-hot-or-zero, so OR-ing masked fields is a clean mux
  always_comb begin
    ra = '0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NRD; i++) ra |= rd_grnt[i] ? rd_addr[i*A +: A] : '0;
    for (int j = 0; j < NWR; j++) begin
      wa |= wr_grnt[j] ? wr_addr[j*A +: A] : '0;
      wd |= wr_grnt[j] ? wr_word[j*W +: W] : '0;
    end
  end
  always_ff @(posedge clk)
    if (|wr_grnt) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_word <= '0;
      rd_vld <= '0;
    end else begin
      rd_vld <= rd_grnt;
      if (|rd_grnt) rd_word <= (BYPASS != 0 && |wr_grnt && wa == ra) ? wd : mem[ra];
    end
endmodule

// File: tb/tb_bank_arb.sv
// tb_bank_arb: fixed-priority/bypass and round-robin/no-bypass instances share stimulus;
// read results go through per-instance scoreboards with expected arrival cycles.
module tb_bank_arb;
  localparam int W = 128, A = 9, N = 3;
  logic clk = 0, rst = 1;
  logic [N-1:0] rd_req = '0, wr_req = '0;
  logic [N*A-1:0] rd_addr = '0, wr_addr = '0;
  logic [N*W-1:0] wr_word = '0;
  logic [N-1:0] f_rg, f_wg, f_rv, r_rg, r_wg, r_rv;
  logic [W-1:0] f_rw, r_rw;
  bank_arb #(.W(W), .A(A), .NRD(N), .NWR(N), .RR(0), .BYPASS(1)) u_fix (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grnt(f_rg), .rd_word(f_rw),
    .rd_vld(f_rv), .wr_req(wr_req), .wr_addr(wr_addr), .wr_word(wr_word), .wr_grnt(f_wg));
  bank_arb #(.W(W), .A(A), .NRD(N), .NWR(N), .RR(1), .BYPASS(0)) u_rr (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grnt(r_rg), .rd_word(r_rw),
    .rd_vld(r_rv), .wr_req(wr_req), .wr_addr(wr_addr), .wr_word(wr_word), .wr_grnt(r_wg));
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;
  typedef struct {
    int due;
    logic [N-1:0] vld;
    logic [W-1:0] word;
  } exp_t;
  exp_t qf[$], qr[$];
  exp_t ef, er;
  int tests = 0, fails = 0;
  localparam logic [W-1:0] A5 = {16{8'hA5}};

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (f_rv != '0) begin
      if (qf.size() == 0) chk("fix unexpected rd_vld", W'(f_rv), '0);
      else begin
        ef = qf.pop_front();
        chk("fix rd arrival cycle", W'(cyc_n), W'(ef.due));
        chk("fix rd_vld", W'(f_rv), W'(ef.vld));
        chk("fix rd_word", f_rw, ef.word);
      end
    end
    if (r_rv != '0) begin
      if (qr.size() == 0) chk("rr unexpected rd_vld", W'(r_rv), '0);
      else begin
        er = qr.pop_front();
        chk("rr rd arrival cycle", W'(cyc_n), W'(er.due));
        chk("rr rd_vld", W'(r_rv), W'(er.vld));
        chk("rr rd_word", r_rw, er.word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int i, input int a);
    rd_addr[i*A +: A] = A'(a);
  endtask

  task automatic set_wa(input int j, input int a, input logic [W-1:0] d);
    wr_addr[j*A +: A] = A'(a);
    wr_word[j*W +: W] = d;
  endtask

  task automatic push(input logic [N-1:0] fv, input logic [W-1:0] fw, input logic [N-1:0] rv,
                      input logic [W-1:0] rw);
    qf.push_back('{due: cyc_n + 1, vld: fv, word: fw});
    qr.push_back('{due: cyc_n + 1, vld: rv, word: rw});
  endtask

  task automatic g(input string nm, input logic [N-1:0] frg, input logic [N-1:0] fwg,
                   input logic [N-1:0] rrg, input logic [N-1:0] rwg);
    @(negedge clk);
    chk({nm, " fix rd_grnt"}, W'(f_rg), W'(frg));
    chk({nm, " fix wr_grnt"}, W'(f_wg), W'(fwg));
    chk({nm, " rr rd_grnt"}, W'(r_rg), W'(rrg));
    chk({nm, " rr wr_grnt"}, W'(r_wg), W'(rwg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rg;
    rd_req = '1;
    wr_req = '1;
    #2;
    chk("reset fix rd_vld", W'(f_rv), '0);
    chk("reset fix rd_word", f_rw, '0);
    chk("reset rr rd_vld", W'(r_rv), '0);
    chk("reset rr rd_word", r_rw, '0);
    chk("reset fix rd_grnt", W'(f_rg), '0);
    chk("reset fix wr_grnt", W'(f_wg), '0);
    chk("reset rr rd_grnt", W'(r_rg), '0);
    chk("reset rr wr_grnt", W'(r_wg), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    rd_req = '0;
    wr_req = '0;
    tick(); wr_req = 3'b001; set_wa(0, 5, A5); g("wr5", 3'b000, 3'b001, 3'b000, 3'b001);
    tick(); wr_req = '0; rd_req = 3'b001; set_ra(0, 5); push(3'b001, A5, 3'b001, A5);
    g("rd5", 3'b001, 3'b000, 3'b001, 3'b000);
    for (int i = 0; i < 8; i++) begin
      tick(); rd_req = '0; wr_req = 3'(1 << (i % 3)); set_wa(i % 3, i, W'(i * 3));
      g("preload", 3'b000, wr_req, 3'b000, wr_req);
    end
    tick(); wr_req = 3'b111;
    set_wa(0, 'h100, W'(1)); set_wa(1, 'h101, W'(2)); set_wa(2, 'h102, W'(3));
    g("wr contention", 3'b000, 3'b001, 3'b000, 3'b100);
    for (int k = 0; k < 4; k++) begin
      tick(); wr_req = '0; rd_req = 3'b111; set_ra(0, 1); set_ra(1, 2); set_ra(2, 3);
      rg = k == 0 ? 3'b010 : k == 1 ? 3'b100 : k == 2 ? 3'b001 : 3'b010;
      push(3'b001, W'(3), rg, rg == 3'b001 ? W'(3) : rg == 3'b010 ? W'(6) : W'(9));
      g("rd contention", 3'b001, 3'b000, rg, 3'b000);
    end
    tick(); rd_req = 3'b100; push(3'b100, W'(9), 3'b100, W'(9));
    g("rd single 2", 3'b100, 3'b000, 3'b100, 3'b000);
    tick(); rd_req = 3'b111; push(3'b001, W'(3), 3'b001, W'(3));
    g("rr ptr at 2", 3'b001, 3'b000, 3'b001, 3'b000);
    for (int i = 0; i < 8; i++) begin
      tick(); rd_req = 3'b001; set_ra(0, i); push(3'b001, W'(i * 3), 3'b001, W'(i * 3));
      g("stream", 3'b001, 3'b000, 3'b001, 3'b000);
    end
    tick(); rd_req = '0; g("idle", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); g("idle", 3'b000, 3'b000, 3'b000, 3'b000);
    chk("hold fix rd_vld", W'(f_rv), '0);
    chk("hold fix rd_word", f_rw, W'(21));
    chk("hold rr rd_vld", W'(r_rv), '0);
    chk("hold rr rd_word", r_rw, W'(21));
    tick(); wr_req = 3'b001; set_wa(0, 'h1FF, W'('h1111)); g("wr 1ff", 3'b000, 3'b001, 3'b000, 3'b001);
    tick(); set_wa(0, 'h1FF, W'('h2222)); rd_req = 3'b001; set_ra(0, 'h1FF);
    push(3'b001, W'('h2222), 3'b001, W'('h1111));
    g("collision", 3'b001, 3'b001, 3'b001, 3'b001);
    tick(); set_wa(0, 6, W'('h77)); push(3'b001, W'('h2222), 3'b001, W'('h2222));
    g("diff addr", 3'b001, 3'b001, 3'b001, 3'b001);
    tick(); wr_req = '0; set_ra(0, 6); push(3'b001, W'('h77), 3'b001, W'('h77));
    g("rd 6", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); rd_req = 3'b111; set_ra(0, 1); set_ra(1, 2); set_ra(2, 3);
    g("pre-reset rd", 3'b001, 3'b000, 3'b010, 3'b000);
    #2 rst = 1;
    #1;
    chk("midrst fix rd_vld", W'(f_rv), '0);
    chk("midrst fix rd_word", f_rw, '0);
    chk("midrst rr rd_vld", W'(r_rv), '0);
    chk("midrst rr rd_word", r_rw, '0);
    chk("midrst rr rd_grnt", W'(r_rg), '0);
    @(posedge clk);
    #1;
    chk("midrst edge fix rd_vld", W'(f_rv), '0);
    chk("midrst edge rr rd_vld", W'(r_rv), '0);
    rst = 0;
    push(3'b001, W'(3), 3'b001, W'(3));
    g("post-reset rd", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); rd_req = '0; g("final idle", 3'b000, 3'b000, 3'b000, 3'b000);
    repeat (3) tick();
    chk("fix scoreboard drained", W'(qf.size()), '0);
    chk("rr scoreboard drained", W'(qr.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
